// File: rtl/sd_spi_pkg.sv
// Shared constants and state encoding for the SPI-mode SD card responder.
package sd_spi_pkg;

   localparam logic [5:0] CMD0  = 6'd0;
   localparam logic [5:0] CMD8  = 6'd8;
   localparam logic [5:0] CMD17 = 6'd17;
   localparam logic [5:0] CMD41 = 6'd41;
   localparam logic [5:0] CMD55 = 6'd55;
   localparam logic [5:0] CMD58 = 6'd58;

   localparam logic [7:0] R1_IDLE    = 8'h01;
   localparam logic [7:0] R1_ILLEGAL = 8'h04;
   localparam logic [7:0] DATA_TOKEN = 8'hFE;

   typedef enum logic [3:0] {
      ST_WAIT_CMD,
      ST_CMD_ARG,
      ST_NCR,
      ST_R1,
      ST_TAIL,
      ST_TOKEN_GAP,
      ST_TOKEN,
      ST_DATA,
      ST_CRC
   } state_t;

endpackage

// File: rtl/sd_spi_responder_if.sv
// SD/SPI link plus backing-memory port; the card side uses the slave modport.
interface sd_spi_responder_if;

   logic        SD_CLK;
   logic        SD_CS;
   logic        SD_MOSI;
   logic        SD_MISO;
   logic [31:0] oMemAddr;
   logic [7:0]  iMemData;
   logic        oBusy;
   logic [5:0]  oLastCmd;

   modport master (
      output SD_CLK, SD_CS, SD_MOSI, iMemData,
      input  SD_MISO, oMemAddr, oBusy, oLastCmd
   );

   modport slave (
      input  SD_CLK, SD_CS, SD_MOSI, iMemData,
      output SD_MISO, oMemAddr, oBusy, oLastCmd
   );

endinterface

// File: rtl/spi_slave_byte.sv
// Oversampling SPI mode-0 byte engine: synchronises the host pins, shifts
// bytes in on SCLK rise and out on SCLK fall, and flags byte boundaries.
module spi_slave_byte (
   input  logic       clk,
   input  logic       reset,
   input  logic       sd_clk,
   input  logic       sd_cs,
   input  logic       sd_mosi,
   input  logic [7:0] tx_byte,
   output logic       miso,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       tx_load,
   output logic       cs_high
);

   logic [1:0] clk_sync;
   logic [1:0] cs_sync;
   logic [1:0] mosi_sync;
   logic       clk_prev;
   logic       cs_prev;
   logic [2:0] bit_cnt;
   logic [7:0] rx_shift;
   logic [7:0] tx_shift;
   logic       sclk_rise;
   logic       sclk_fall;
   logic       cs_fall;

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync  <= 2'b00;
         cs_sync   <= 2'b11;
         mosi_sync <= 2'b00;
         clk_prev  <= 1'b0;
         cs_prev   <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[0], sd_clk};
         cs_sync   <= {cs_sync[0], sd_cs};
         mosi_sync <= {mosi_sync[0], sd_mosi};
         clk_prev  <= clk_sync[1];
         cs_prev   <= cs_sync[1];
      end
   end

   // A new transmit byte starts on CS fall, or on the first fall after bit 0.
   always_comb begin
      cs_high   = cs_sync[1];
      sclk_rise = clk_sync[1] & ~clk_prev;
      sclk_fall = ~clk_sync[1] & clk_prev;
      cs_fall   = ~cs_sync[1] & cs_prev;
      tx_load   = ~cs_sync[1] & (cs_fall | (sclk_fall & (bit_cnt == 3'd0)));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt  <= 3'd0;
         rx_shift <= 8'h00;
         tx_shift <= 8'hFF;
         miso     <= 1'b1;
         rx_byte  <= 8'h00;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (cs_sync[1]) begin
            bit_cnt  <= 3'd0;
            tx_shift <= 8'hFF;
            miso     <= 1'b1;
         end else begin
            if (sclk_rise) begin
               rx_shift <= {rx_shift[6:0], mosi_sync[1]};
               bit_cnt  <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  rx_byte  <= {rx_shift[6:0], mosi_sync[1]};
                  rx_valid <= 1'b1;
               end
            end
            if (tx_load) begin
               tx_shift <= tx_byte;
               miso     <= tx_byte[7];
            end else if (sclk_fall) begin
               tx_shift <= {tx_shift[6:0], 1'b1};
               miso     <= tx_shift[6];
            end
         end
      end
   end

endmodule

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card emulator: decodes command frames, answers the init
// subset and streams single-block reads from a byte-wide memory port.
module sd_spi_responder
   import sd_spi_pkg::*;
#(
   parameter int          BLOCK_BYTES = 512,
   parameter int          NCR_BYTES   = 1,
   parameter logic [31:0] OCR_VALUE   = 32'hC0FF8000
) (
   input logic                iCLK,
   input logic                Reset,
   sd_spi_responder_if.slave  bus
);

   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic        tx_load;
   logic        cs_high;
   logic        miso;
   logic [7:0]  tx_byte;

   state_t      state;
   state_t      state_next;
   logic        frame_done;
   logic [15:0] cnt;
   logic [5:0]  cmd_idx;
   logic [31:0] arg;
   logic [7:0]  r1;
   logic [31:0] tail;
   logic        has_tail;
   logic        has_data;
   logic        idle_flag;
   logic        app_flag;
   logic [31:0] mem_addr;
   logic        busy;
   logic [5:0]  last_cmd;
   logic [7:0]  idle_r1;

   spi_slave_byte u_byte (
      .clk      (iCLK),
      .reset    (Reset),
      .sd_clk   (bus.SD_CLK),
      .sd_cs    (bus.SD_CS),
      .sd_mosi  (bus.SD_MOSI),
      .tx_byte  (tx_byte),
      .miso     (miso),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .tx_load  (tx_load),
      .cs_high  (cs_high)
   );

   assign bus.SD_MISO  = miso;
   assign bus.oMemAddr = mem_addr;
   assign bus.oBusy    = busy;
   assign bus.oLastCmd = last_cmd;
   assign idle_r1      = {7'b0, idle_flag};

   // Every transition happens at a received-byte boundary; the byte the next
   // slot transmits is then chosen from the new state.
   always_comb begin
      state_next = state;
      frame_done = 1'b0;
      tx_byte    = 8'hFF;
      if (rx_valid) begin
         case (state)
            ST_WAIT_CMD:  if (rx_byte[7:6] == 2'b01) state_next = ST_CMD_ARG;
            ST_CMD_ARG:   if (cnt == 16'd4) begin
                             state_next = ST_NCR;
                             frame_done = ~cs_high;
                          end
            ST_NCR:       if (cnt == 16'(NCR_BYTES - 1)) state_next = ST_R1;
            ST_R1:        state_next = has_tail ? ST_TAIL :
                                       has_data ? ST_TOKEN_GAP : ST_WAIT_CMD;
            ST_TAIL:      if (cnt == 16'd3) state_next = ST_WAIT_CMD;
            ST_TOKEN_GAP: state_next = ST_TOKEN;
            ST_TOKEN:     state_next = ST_DATA;
            ST_DATA:      if (cnt == 16'(BLOCK_BYTES - 1)) state_next = ST_CRC;
            ST_CRC:       if (cnt == 16'd1) state_next = ST_WAIT_CMD;
            default:      state_next = ST_WAIT_CMD;
         endcase
      end
      if (cs_high) state_next = ST_WAIT_CMD;
      case (state)
         ST_R1:    tx_byte = r1;
         ST_TAIL:  tx_byte = tail[31:24];
         ST_TOKEN: tx_byte = DATA_TOKEN;
         ST_DATA:  tx_byte = bus.iMemData;
         default:  tx_byte = 8'hFF;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (Reset) begin
         state    <= ST_WAIT_CMD;
         cnt      <= 16'd0;
         busy     <= 1'b0;
      end else begin
         state    <= state_next;
         busy     <= !(state_next inside {ST_WAIT_CMD, ST_CMD_ARG});
         if (state_next != state) cnt <= 16'd0;
         else if (rx_valid)       cnt <= cnt + 16'd1;
      end
   end

   // Command decode: R1 reflects idle_flag as it was before this command.
   always_ff @(posedge iCLK) begin
      if (Reset) begin
         cmd_idx   <= 6'd0;
         arg       <= 32'd0;
         r1        <= 8'hFF;
         tail      <= 32'd0;
         has_tail  <= 1'b0;
         has_data  <= 1'b0;
         idle_flag <= 1'b1;
         app_flag  <= 1'b0;
         mem_addr  <= 32'd0;
         last_cmd  <= 6'd0;
      end else begin
         if (state == ST_WAIT_CMD && state_next == ST_CMD_ARG)
            cmd_idx <= rx_byte[5:0];
         if (rx_valid && state == ST_CMD_ARG && cnt < 16'd4)
            arg <= {arg[23:0], rx_byte};
         if (rx_valid && state == ST_TAIL)
            tail <= {tail[23:0], 8'hFF};
         if (tx_load && state == ST_DATA)
            mem_addr <= mem_addr + 32'd1;
         if (frame_done) begin
            last_cmd <= cmd_idx;
            r1       <= idle_r1 | R1_ILLEGAL;
            has_tail <= 1'b0;
            has_data <= 1'b0;
            app_flag <= 1'b0;
            case (cmd_idx)
               CMD0: begin
                  r1        <= R1_IDLE;
                  idle_flag <= 1'b1;
               end
               CMD8: begin
                  r1       <= idle_r1;
                  tail     <= {16'h0000, (arg[11:8] == 4'h1) ? 8'h01 : 8'h00, arg[7:0]};
                  has_tail <= 1'b1;
               end
               CMD55: begin
                  r1       <= idle_r1;
                  app_flag <= 1'b1;
               end
               CMD41: if (app_flag) begin
                  r1        <= idle_r1;
                  idle_flag <= 1'b0;
               end
               CMD58: begin
                  r1       <= idle_r1;
                  tail     <= OCR_VALUE;
                  has_tail <= 1'b1;
               end
               CMD17: if (!idle_flag) begin
                  r1       <= 8'h00;
                  has_data <= 1'b1;
                  mem_addr <= arg * 32'(BLOCK_BYTES);
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Randomised host-side bench for sd_spi_responder; expected response bytes
// come from a command-level model of the card.
module tb_sd_spi_responder;
   import sd_spi_pkg::*;

   localparam int          TB_BLOCK = 16;
   localparam int          TB_NCR   = 1;
   localparam int          HALF     = 50;
   localparam logic [31:0] TB_OCR   = 32'hC0FF8000;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   sd_spi_responder_if bus();

   sd_spi_responder #(
      .BLOCK_BYTES (TB_BLOCK),
      .NCR_BYTES   (TB_NCR),
      .OCR_VALUE   (TB_OCR)
   ) dut (
      .iCLK  (clk),
      .Reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int         check_count = 0;
   int         err_count   = 0;
   logic [7:0] mem_key     = 8'h00;
   logic       m_idle      = 1'b1;
   logic       m_app       = 1'b0;
   logic [5:0] last_idx    = 6'd0;
   logic [7:0] exp_q[$];

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      return a[7:0] ^ mem_key;
   endfunction

   always @(posedge clk) bus.iMemData <= mem_byte(bus.oMemAddr);

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_count++;
      if (got !== exp) begin
         err_count++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Card behaviour at command level: the full byte stream after the frame.
   task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg);
      logic [7:0]  r1;
      logic [31:0] base;
      exp_q.delete();
      for (int i = 0; i < TB_NCR; i++) exp_q.push_back(8'hFF);
      r1 = m_idle ? 8'h01 : 8'h00;
      case (idx)
         6'd0:  begin exp_q.push_back(8'h01); m_idle = 1'b1; end
         6'd8:  begin
            exp_q.push_back(r1);
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h00);
            exp_q.push_back((arg[11:8] == 4'h1) ? 8'h01 : 8'h00);
            exp_q.push_back(arg[7:0]);
         end
         6'd55: exp_q.push_back(r1);
         6'd41: if (m_app) begin exp_q.push_back(r1); m_idle = 1'b0; end
                else exp_q.push_back(r1 | 8'h04);
         6'd58: begin
            exp_q.push_back(r1);
            for (int i = 3; i >= 0; i--) exp_q.push_back(8'(TB_OCR >> (8 * i)));
         end
         6'd17: if (m_idle) exp_q.push_back(8'h05);
         else begin
            base = arg * TB_BLOCK;
            exp_q.push_back(8'h00);
            exp_q.push_back(8'hFF);
            exp_q.push_back(8'hFE);
            for (int i = 0; i < TB_BLOCK; i++) exp_q.push_back(mem_byte(base + 32'(i)));
            exp_q.push_back(8'hFF);
            exp_q.push_back(8'hFF);
         end
         default: exp_q.push_back(r1 | 8'h04);
      endcase
      m_app = (idx == 6'd55);
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         bus.SD_MOSI = tx[i];
         #(HALF);
         rx[i] = bus.SD_MISO;
         bus.SD_CLK = 1'b1;
         #(HALF);
         bus.SD_CLK = 1'b0;
      end
   endtask

   // One CS-framed transaction: junk bytes, a command frame, then the reply
   // (cut short by raising CS when abort_after is non-zero).
   task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg,
                                input int junk, input int abort_after);
      logic [7:0] frame [6];
      logic [7:0] rx;
      logic [7:0] b;
      int         n;
      frame[0] = {2'b01, idx};
      frame[1] = arg[31:24];
      frame[2] = arg[23:16];
      frame[3] = arg[15:8];
      frame[4] = arg[7:0];
      frame[5] = 8'(($urandom_range(0, 127) << 1) | 1);
      model_cmd(idx, arg);
      bus.SD_CS = 1'b0;
      #(2 * HALF);
      for (int j = 0; j < junk; j++) begin
         b = 8'($urandom);
         if (b[7:6] == 2'b01) b[7] = 1'b1;
         spi_byte(b, rx);
         checkOutput("junk_miso", rx, 8'hFF);
      end
      for (int j = 0; j < 6; j++) begin
         spi_byte(frame[j], rx);
         checkOutput("frame_miso", rx, 8'hFF);
      end
      #(HALF);
      checkOutput("busy_set", bus.oBusy, 1'b1);
      n = (abort_after > 0 && abort_after < exp_q.size()) ? abort_after : exp_q.size();
      for (int j = 0; j < n; j++) begin
         spi_byte(8'($urandom), rx);
         checkOutput($sformatf("cmd%0d_resp[%0d]", idx, j), rx, exp_q[j]);
      end
      if (n == exp_q.size()) begin
         #(HALF);
         checkOutput("busy_clear", bus.oBusy, 1'b0);
      end
      bus.SD_MOSI = 1'b1;
      bus.SD_CS   = 1'b1;
      #(4 * HALF);
      checkOutput("miso_cs_high", bus.SD_MISO, 1'b1);
      checkOutput("busy_cs_high", bus.oBusy, 1'b0);
      checkOutput("last_cmd", bus.oLastCmd, idx);
      last_idx = idx;
   endtask

   task automatic abort_frame();
      logic [7:0] rx;
      bus.SD_CS = 1'b0;
      #(2 * HALF);
      spi_byte(8'h51, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h00, rx);
      bus.SD_CS = 1'b1;
      #(4 * HALF);
      checkOutput("abort_frame_busy", bus.oBusy, 1'b0);
      checkOutput("abort_frame_miso", bus.SD_MISO, 1'b1);
      checkOutput("abort_frame_last", bus.oLastCmd, last_idx);
   endtask

   initial begin
      #1_500_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0]  rx;
      logic [5:0]  idx;
      logic [31:0] arg;
      int          abort_after;
      bus.SD_CLK  = 1'b0;
      bus.SD_CS   = 1'b1;
      bus.SD_MOSI = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_miso", bus.SD_MISO, 1'b1);
      checkOutput("reset_addr", bus.oMemAddr, 32'd0);
      checkOutput("reset_busy", bus.oBusy, 1'b0);
      checkOutput("reset_last", bus.oLastCmd, 6'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      applyStimulus(CMD0, 32'h0, 2, 0);
      applyStimulus(CMD8, 32'h000001AA, 0, 0);
      applyStimulus(CMD17, 32'h5, 0, 0);
      applyStimulus(6'd13, 32'h0, 0, 0);
      abort_frame();
      applyStimulus(CMD55, 32'h0, 0, 0);
      applyStimulus(CMD41, 32'h40000000, 0, 0);
      applyStimulus(CMD55, 32'h0, 1, 0);
      applyStimulus(CMD41, 32'h40000000, 0, 0);
      applyStimulus(CMD58, 32'h0, 0, 0);
      applyStimulus(6'd13, 32'h0, 0, 0);
      applyStimulus(CMD41, 32'h0, 0, 0);
      mem_key = 8'h00;
      applyStimulus(CMD17, 32'd2, 0, 0);
      mem_key = 8'h5A;
      applyStimulus(CMD17, 32'hFFFF_FFF0, 0, 4 * TB_NCR + 13);
      applyStimulus(CMD58, 32'h0, 0, 0);

      for (int k = 0; k < 8; k++) begin
         case ($urandom_range(0, 7))
            0: idx = CMD0;
            1: idx = CMD8;
            2: idx = CMD17;
            3: idx = CMD41;
            4: idx = CMD55;
            5: idx = CMD58;
            6: idx = CMD17;
            default: idx = 6'($urandom);
         endcase
         arg = $urandom;
         if (idx == CMD8) arg[11:8] = 4'($urandom_range(0, 2));
         mem_key = 8'($urandom);
         abort_after = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
         applyStimulus(idx, arg, $urandom_range(0, 2), abort_after);
      end

      // Reset in the middle of a block read must drop everything at once.
      applyStimulus(CMD55, 32'h0, 0, 0);
      applyStimulus(CMD41, 32'h0, 0, 0);
      bus.SD_CS = 1'b0;
      #(2 * HALF);
      spi_byte(8'h51, rx);
      for (int j = 0; j < 5; j++) spi_byte(8'h00, rx);
      for (int j = 0; j < 5; j++) spi_byte(8'hFF, rx);
      reset     = 1'b1;
      bus.SD_CS = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("midreset_miso", bus.SD_MISO, 1'b1);
      checkOutput("midreset_busy", bus.oBusy, 1'b0);
      checkOutput("midreset_addr", bus.oMemAddr, 32'd0);
      checkOutput("midreset_last", bus.oLastCmd, 6'd0);
      reset    = 1'b0;
      m_idle   = 1'b1;
      m_app    = 1'b0;
      last_idx = 6'd0;
      #(4 * HALF);
      applyStimulus(CMD17, 32'h1, 0, 0);

      $display("Result: errors=%0d of %0d checks", err_count, check_count);
      $finish;
   end

endmodule

// File: doc/sd_spi_responder.md
Name: sd_spi_responder

Overview:
- SPI-mode SD card emulator: the card end of the SD/SPI link driven by the host-side SD controller.
- Decodes 6-byte command frames and answers the CMD0/CMD8/CMD55/ACMD41/CMD58/CMD17 subset.
- Serves single-block reads from an attached byte-wide synchronous ROM/RAM port.
- Used in simulation and FPGA loopback to exercise the host SD path without a physical card.

Parameters:
BLOCK_BYTES, 512, bytes per data block returned by CMD17
NCR_BYTES, 1, 0xFF filler bytes between command end and R1 (1..8)
OCR_VALUE, 32'hC0FF8000, OCR returned by CMD58 (CCS=1, block addressing)

Ports:
iCLK  in  1  system clock; must be at least 8x SD_CLK frequency
Reset  in  1  synchronous, active-high reset
SD_CLK  in  1  SPI clock from host, mode 0 (CPOL=0, CPHA=0)
SD_CS  in  1  chip select from host, active low
SD_MOSI  in  1  host-to-card serial data, MSB first
SD_MISO  out  1  card-to-host serial data, MSB first
oMemAddr  out  32  byte address into backing memory
iMemData  in  8  memory data, valid one iCLK after oMemAddr changes
oBusy  out  1  high from the last command byte until the response/data/CRC completes
oLastCmd  out  6  index of the last fully received command

Behaviour:
- Synchronisation and edge detection:
  - SD_CLK, SD_CS and SD_MOSI each pass through 2-flop synchronisers on iCLK.
  - Edges of SD_CLK are detected on the synchronised signal.
- Bit timing:
  - MOSI is sampled on the detected rising edge.
  - SD_MISO updates on the detected falling edge.
  - The MSB of each transmit byte is driven immediately after the falling edge that follows bit 0 of the previous byte, or on CS fall for the first byte.
  - A 3-bit bit counter clears whenever SD_CS is high.
- Reset values:
  - SD_MISO=1, oMemAddr=0, oBusy=0, oLastCmd=0.
  - State=WAIT_CMD, idle_flag=1, app_flag=0.
- States:
  - WAIT_CMD: clock in bytes while transmitting 0xFF. A byte with bits[7:6]=2'b01 is the start byte: latch index=bits[5:0], go to CMD_ARG.
  - CMD_ARG: receive 4 argument bytes (MSB first) plus 1 CRC byte. CRC is ignored. Then go to NCR, set oBusy, update oLastCmd.
  - NCR: transmit NCR_BYTES of 0xFF, then go to R1.
  - R1: transmit the R1 byte, then go to TAIL, TOKEN_GAP or WAIT_CMD depending on the command.
  - TAIL: transmit 4 extra bytes (R7 for CMD8, OCR for CMD58), then go to WAIT_CMD.
  - TOKEN_GAP: transmit one 0xFF byte, then go to TOKEN.
  - TOKEN: transmit 0xFE, then go to DATA.
  - DATA: transmit BLOCK_BYTES bytes from memory, then go to CRC.
  - CRC: transmit 2 bytes of 0xFF, then go to WAIT_CMD and clear oBusy.
- Command decode (R1 bit0 = idle_flag, sampled before the update):
  - CMD0: R1=0x01; set idle_flag; clear app_flag.
  - CMD8: R1 plus tail {0x00, 0x00, arg[11:8]&4'h1 as 8'h01 when voltage nibble=1 else 8'h00, arg[7:0]}.
  - CMD55: R1; set app_flag.
  - CMD41 with app_flag=1: R1 reports the current idle_flag, then idle_flag is cleared. This gives 0x01 on the first ACMD41 and 0x00 thereafter.
  - CMD41 without app_flag: illegal.
  - app_flag clears after any command other than CMD55.
  - CMD58: R1 plus tail = OCR_VALUE, MSB byte first.
  - CMD17 with idle_flag=0: R1=0x00, then the data path. oMemAddr = arg*BLOCK_BYTES, incremented once per transmitted data byte.
  - CMD17 with idle_flag=1: R1=0x05, no data phase.
  - Any other index: R1 = idle_flag|0x04; return to WAIT_CMD.
- Memory timing:
  - oMemAddr for byte n is presented at the start of byte n-1's transmission.
  - iMemData is captured into the transmit shift register at the byte boundary.
  - This guarantees at least 8 SD_CLK periods of read latency.
- Width and address rules:
  - arg*BLOCK_BYTES is a 32-bit product; wraps modulo 2^32.
  - The address increment wraps at 2^32.
- Boundary conditions:
  - SD_CS rising at any point (mid-command, mid-data): abort to WAIT_CMD, SD_MISO=1, oBusy=0.
  - idle_flag and app_flag are retained across a CS abort.
  - MOSI content outside WAIT_CMD/CMD_ARG is ignored.
  - A command byte lacking the 01 prefix in WAIT_CMD is discarded.
  - Reset overrides all in-progress transfers on the same cycle.

Decomposition:
- Shared package sd_spi_pkg holds:
  - Command index constants CMD0/8/17/41/55/58.
  - R1 bit masks (IDLE=0x01, ILLEGAL=0x04).
  - DATA_TOKEN=8'hFE.
  - The state enumeration.
- One natural sub-module, spi_slave_byte:
  - Synchronisers, edge detect, bit counter, shift registers.
  - Outputs rx_byte/rx_valid pulse and a tx_load strobe.
  - The top module holds the command FSM and the memory address counter.

Test Plan:
1. Reset, then CMD0 frame 40 00 00 00 00 95 -> one 0xFF NCR, then R1=0x01; oLastCmd=0; oBusy falls after R1.
2. CMD8 arg 0x000001AA -> R1=0x01, tail 00 00 01 AA.
3. CMD55 + ACMD41 twice -> first R1=0x01, second R1=0x00; then CMD58 -> 0x00, C0 FF 80 00.
4. After init, CMD17 arg 2 with memory[i]=i[7:0] -> FF, R1=0x00, FF, FE, bytes 0x00..0xFF twice (addresses 1024..1535), FF FF.
5. CMD17 before init -> R1=0x05, no FE token; unknown CMD13 -> R1=0x05 (idle) or 0x04 (after init).
6. CS raised after 100 data bytes, then CMD58 issued -> SD_MISO=1 while CS high, new response correct, idle_flag preserved (R1=0x00).
